// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
// Bundles the D-stage decode information, the per-stage result buses and the
// hazard/forwarding results that flow between the pipeline and the
// hazard scoreboard.
//
// master modport (pipeline side):
//   drives  d_wen, d_wreg, d_tnew, d_rs, d_rt, d_use_rs, d_use_rt,
//           d_tuse_rs, d_tuse_rt, d_md_start, d_md_is_div, d_md_use,
//           flush, stage_data, rf_rs_data, rf_rt_data
//   reads   stall, fwd_sel_rs, fwd_sel_rt, fwd_data_rs, fwd_data_rt,
//           md_busy, md_done
// slave modport (scoreboard side): the same signals with directions reversed.
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
    parameter int STAGES = 3,
    parameter int DW     = 32,
    parameter int TNEW_W = 2,
    parameter int SEL_W  = $clog2(STAGES + 1)
);
    logic                 d_wen;
    logic [4:0]           d_wreg;
    logic [TNEW_W-1:0]    d_tnew;
    logic [4:0]           d_rs;
    logic [4:0]           d_rt;
    logic                 d_use_rs;
    logic                 d_use_rt;
    logic [1:0]           d_tuse_rs;
    logic [1:0]           d_tuse_rt;
    logic                 d_md_start;
    logic                 d_md_is_div;
    logic                 d_md_use;
    logic                 flush;
    logic [STAGES*DW-1:0] stage_data;
    logic [DW-1:0]        rf_rs_data;
    logic [DW-1:0]        rf_rt_data;
    logic                 stall;
    logic [SEL_W-1:0]     fwd_sel_rs;
    logic [SEL_W-1:0]     fwd_sel_rt;
    logic [DW-1:0]        fwd_data_rs;
    logic [DW-1:0]        fwd_data_rt;
    logic                 md_busy;
    logic                 md_done;

    modport master (
        output d_wen, d_wreg, d_tnew, d_rs, d_rt, d_use_rs, d_use_rt,
               d_tuse_rs, d_tuse_rt, d_md_start, d_md_is_div, d_md_use,
               flush, stage_data, rf_rs_data, rf_rt_data,
        input  stall, fwd_sel_rs, fwd_sel_rt, fwd_data_rs, fwd_data_rt,
               md_busy, md_done
    );

    modport slave (
        input  d_wen, d_wreg, d_tnew, d_rs, d_rt, d_use_rs, d_use_rt,
               d_tuse_rs, d_tuse_rt, d_md_start, d_md_is_div, d_md_use,
               flush, stage_data, rf_rs_data, rf_rt_data,
        output stall, fwd_sel_rs, fwd_sel_rt, fwd_data_rs, fwd_data_rt,
               md_busy, md_done
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Registered hazard and forwarding unit for the MIPS pipeline. Every in-flight
// register write in the post-decode stages is tracked as {valid, wen, wreg,
// tnew}; the D-stage stall, forward selects and forwarded data are derived
// from that table plus the current D-stage decode. A busy counter models the
// multi-cycle mult/div unit.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    hazard_scoreboard_if.slave: D decode inputs, flush, per-stage
//          result buses, register-file data in; stall, forward selects,
//          forwarded data, md_busy, md_done out
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int STAGES   = 3,
    parameter int DW       = 32,
    parameter int TNEW_W   = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int SEL_W    = $clog2(STAGES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  bus
);
    localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CNT_W  = $clog2(MD_MAX + 1);
    localparam int CMP_W  = TNEW_W + 2;

    logic [STAGES-1:0] ent_valid;
    logic [STAGES-1:0] ent_wen;
    logic [4:0]        ent_wreg [STAGES];
    logic [TNEW_W-1:0] ent_tnew [STAGES];

    logic [CNT_W-1:0]  md_cnt;
    logic [CNT_W-1:0]  md_next;
    logic              md_done_q;

    logic              stall_rs;
    logic              stall_rt;
    logic              hit_rs;
    logic              hit_rt;
    logic              stall_int;
    logic [SEL_W-1:0]  sel_rs;
    logic [SEL_W-1:0]  sel_rt;
    logic [DW-1:0]     data_rs;
    logic [DW-1:0]     data_rt;

    // Scan the table from youngest (entry 0) to oldest. Any matching entry
    // whose result is later than the operand's use forces a stall, but only
    // the youngest match may supply forwarded data; older matches hold stale
    // values once a younger writer of the same register exists.
    always_comb begin
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        hit_rs   = 1'b0;
        hit_rt   = 1'b0;
        sel_rs   = '0;
        sel_rt   = '0;
        data_rs  = bus.rf_rs_data;
        data_rt  = bus.rf_rt_data;
        for (int s = 0; s < STAGES; s++) begin
            if (ent_valid[s] && ent_wen[s] && (ent_wreg[s] == bus.d_rs) && (bus.d_rs != 5'd0)) begin
                if (bus.d_use_rs && ({2'b00, ent_tnew[s]} > {{TNEW_W{1'b0}}, bus.d_tuse_rs}))
                    stall_rs = 1'b1;
                if (!hit_rs) begin
                    hit_rs = 1'b1;
                    if (ent_tnew[s] == '0) begin
                        sel_rs  = SEL_W'(s + 1);
                        data_rs = bus.stage_data[s*DW +: DW];
                    end
                end
            end
            if (ent_valid[s] && ent_wen[s] && (ent_wreg[s] == bus.d_rt) && (bus.d_rt != 5'd0)) begin
                if (bus.d_use_rt && ({2'b00, ent_tnew[s]} > {{TNEW_W{1'b0}}, bus.d_tuse_rt}))
                    stall_rt = 1'b1;
                if (!hit_rt) begin
                    hit_rt = 1'b1;
                    if (ent_tnew[s] == '0) begin
                        sel_rt  = SEL_W'(s + 1);
                        data_rt = bus.stage_data[s*DW +: DW];
                    end
                end
            end
        end
    end

    assign stall_int       = stall_rs | stall_rt | (bus.d_md_use && (md_cnt != '0));
    assign bus.stall       = stall_int;
    assign bus.fwd_sel_rs  = sel_rs;
    assign bus.fwd_sel_rt  = sel_rt;
    assign bus.fwd_data_rs = data_rs;
    assign bus.fwd_data_rt = data_rt;
    assign bus.md_busy     = (md_cnt != '0);
    assign bus.md_done     = md_done_q;

    // Scoreboard shift register. Entries age by one stage per clock with
    // their tnew counting down to zero. A stalled D instruction will be
    // re-presented, so it enters as a bubble instead. Flush wipes the table
    // and wins over both the shift and the load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_valid <= '0;
            ent_wen   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                ent_wreg[k] <= '0;
                ent_tnew[k] <= '0;
            end
        end else if (bus.flush) begin
            ent_valid <= '0;
            ent_wen   <= '0;
            for (int k = 0; k < STAGES; k++)
                ent_tnew[k] <= '0;
        end else begin
            for (int k = 1; k < STAGES; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_wen[k]   <= ent_wen[k-1];
                ent_wreg[k]  <= ent_wreg[k-1];
                ent_tnew[k]  <= (ent_tnew[k-1] == '0) ? '0 : ent_tnew[k-1] - TNEW_W'(1);
            end
            if (stall_int) begin
                ent_valid[0] <= 1'b0;
                ent_wen[0]   <= 1'b0;
                ent_wreg[0]  <= '0;
                ent_tnew[0]  <= '0;
            end else begin
                ent_valid[0] <= 1'b1;
                ent_wen[0]   <= bus.d_wen && (bus.d_wreg != 5'd0);
                ent_wreg[0]  <= bus.d_wreg;
                ent_tnew[0]  <= bus.d_tnew;
            end
        end
    end

    // Next value of the mult/div busy counter. Only a D instruction that
    // actually issues (not stalled, not flushed) may start the unit.
    always_comb begin
        md_next = md_cnt;
        if (!bus.flush && !stall_int && bus.d_md_start)
            md_next = bus.d_md_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        else if (md_cnt != '0)
            md_next = md_cnt - CNT_W'(1);
    end

    // Busy counter and its completion pulse, which is registered so that it
    // is high for exactly the cycle after the counter expires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt    <= '0;
            md_done_q <= 1'b0;
        end else begin
            md_cnt    <= md_next;
            md_done_q <= (md_cnt == CNT_W'(1)) && (md_next == '0);
        end
    end
endmodule
